// File: rtl/psram_pkg.sv
// Shared LY68S3200 PSRAM definitions: command opcodes, responder states and timing defaults.
// memCtrl imports the same opcodes so both ends of the QPI link agree.
package psram_pkg;

  localparam logic [7:0] PSRAM_CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] PSRAM_CMD_QPI_EXIT  = 8'hF5;
  localparam logic [7:0] PSRAM_CMD_WRITE     = 8'h38;
  localparam logic [7:0] PSRAM_CMD_READ      = 8'hEB;

  localparam int unsigned PSRAM_WAIT_CYCLES_DEF = 6;

  typedef enum logic [2:0] {
    IDLE,
    SPI_CMD,
    QPI_CMD,
    ADDR,
    WR_DATA,
    RD_WAIT,
    RD_DATA,
    IGNORE
  } psram_state_e;

endpackage

// File: rtl/psram_mem_array.sv
// Single-port byte RAM behind the PSRAM responder: synchronous write, combinational read.
module psram_mem_array
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [7:0]           wdata_i,
  output logic [7:0]           rdata_o
);

  logic [7:0] mem_q [2**ADDR_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_qpi_responder.sv
// Responder side of the LY68S3200 QPI link: decodes SPI/QPI commands and 24-bit
// addresses and serves write/read bursts from an aliased internal byte array.
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 12,
  parameter int unsigned WAIT_CYCLES   = PSRAM_WAIT_CYCLES_DEF,
  parameter logic [7:0]  CMD_QPI_ENTER = PSRAM_CMD_QPI_ENTER,
  parameter logic [7:0]  CMD_QPI_EXIT  = PSRAM_CMD_QPI_EXIT,
  parameter logic [7:0]  CMD_WRITE     = PSRAM_CMD_WRITE,
  parameter logic [7:0]  CMD_READ      = PSRAM_CMD_READ
) (
  input  logic       i_clkRAM,
  input  logic       reset,
  input  logic       i_psram_cs,
  input  logic [3:0] i_psram_data,
  output logic [3:0] o_psram_data,
  output logic       o_psram_oe,
  output logic       o_qpi_mode,
  output logic       o_bad_cmd
);

  psram_state_e         state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           hi_q, hi_d;
  logic                 isRead_q, isRead_d;
  logic                 lowNext_q, lowNext_d;
  logic [3:0]           data_q, data_d;
  logic                 oe_q, oe_d;
  logic                 qpi_q, qpi_d;
  logic                 bad_q, bad_d;

  logic                 memWe;
  logic [7:0]           memWdata;
  logic [7:0]           memRdata;
  logic [7:0]           cmdSpi;
  logic [7:0]           cmdQpi;

  // Reads and writes share addr_q, so a single-port array suffices.
  psram_mem_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk_i   (i_clkRAM),
    .we_i    (memWe & reset),
    .addr_i  (addr_q),
    .wdata_i (memWdata),
    .rdata_o (memRdata)
  );

  assign cmdSpi = {cmd_q[6:0], i_psram_data[0]};
  assign cmdQpi = {cmd_q[3:0], i_psram_data};

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    hi_d      = hi_q;
    isRead_d  = isRead_q;
    lowNext_d = lowNext_q;
    data_d    = data_q;
    oe_d      = oe_q;
    qpi_d     = qpi_q;
    bad_d     = 1'b0;
    memWe     = 1'b0;
    memWdata  = {hi_q, i_psram_data};

    if (i_psram_cs) begin
      state_d   = IDLE;
      oe_d      = 1'b0;
      cnt_d     = '0;
      lowNext_d = 1'b0;
      data_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 8'd1;
          if (!qpi_q) begin
            cmd_d   = cmdSpi;
            state_d = SPI_CMD;
          end else begin
            cmd_d   = cmdQpi;
            state_d = QPI_CMD;
          end
        end
        SPI_CMD: begin
          cmd_d = cmdSpi;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = '0;
            state_d = IGNORE;
            if (cmdSpi == CMD_QPI_ENTER) qpi_d = 1'b1;
            else                         bad_d = 1'b1;
          end
        end
        QPI_CMD: begin
          cmd_d = cmdQpi;
          cnt_d = '0;
          if (cmdQpi == CMD_WRITE) begin
            isRead_d = 1'b0;
            state_d  = ADDR;
          end else if (cmdQpi == CMD_READ) begin
            isRead_d = 1'b1;
            state_d  = ADDR;
          end else if (cmdQpi == CMD_QPI_EXIT) begin
            qpi_d   = 1'b0;
            state_d = IGNORE;
          end else begin
            bad_d   = 1'b1;
            state_d = IGNORE;
          end
        end
        // Upper address bits fall off the top of the shift, giving the aliasing.
        ADDR: begin
          addr_d = {addr_q[ADDR_BITS-5:0], i_psram_data};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd5) begin
            cnt_d     = '0;
            lowNext_d = 1'b0;
            state_d   = isRead_q ? RD_WAIT : WR_DATA;
          end
        end
        WR_DATA: begin
          if (!lowNext_q) begin
            hi_d      = i_psram_data;
            lowNext_d = 1'b1;
          end else begin
            memWe     = 1'b1;
            addr_d    = addr_q + ADDR_BITS'(1);
            lowNext_d = 1'b0;
          end
        end
        RD_WAIT: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
            cnt_d     = '0;
            data_d    = memRdata[7:4];
            oe_d      = 1'b1;
            lowNext_d = 1'b1;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (lowNext_q) begin
            data_d    = memRdata[3:0];
            addr_d    = addr_q + ADDR_BITS'(1);
            lowNext_d = 1'b0;
          end else begin
            data_d    = memRdata[7:4];
            lowNext_d = 1'b1;
          end
        end
        IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clkRAM) begin
    if (!reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      isRead_q  <= 1'b0;
      lowNext_q <= 1'b0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      qpi_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      hi_q      <= hi_d;
      isRead_q  <= isRead_d;
      lowNext_q <= lowNext_d;
      data_q    <= data_d;
      oe_q      <= oe_d;
      qpi_q     <= qpi_d;
      bad_q     <= bad_d;
    end
  end

  assign o_psram_data = data_q;
  assign o_psram_oe   = oe_q;
  assign o_qpi_mode   = qpi_q;
  assign o_bad_cmd    = bad_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: drives SPI/QPI transactions on the negative
// edge and compares outputs 1 time unit after each rising edge against hand-computed values.
module tb_psram_qpi_responder;

  localparam int WAIT = 6;

  logic       clk = 1'b0;
  logic       resetN;
  logic       cs;
  logic [3:0] sioIn;
  logic [3:0] sioOut;
  logic       oe;
  logic       qpi;
  logic       bad;

  int checks   = 0;
  int errors   = 0;
  int badCount = 0;

  logic [7:0] rb0, rb1;

  always #5 clk = ~clk;

  psram_qpi_responder dut (
    .i_clkRAM     (clk),
    .reset        (resetN),
    .i_psram_cs   (cs),
    .i_psram_data (sioIn),
    .o_psram_data (sioOut),
    .o_psram_oe   (oe),
    .o_qpi_mode   (qpi),
    .o_bad_cmd    (bad)
  );

  // Every cycle with o_bad_cmd high adds one, so a lone 1-cycle pulse adds exactly one.
  always @(posedge clk) begin
    #1;
    if (bad === 1'b1) badCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic csVal, input logic [3:0] dataVal);
    @(negedge clk);
    cs    = csVal;
    sioIn = dataVal;
    @(posedge clk);
    #1;
  endtask

  task automatic csHigh();
    applyStimulus(1'b1, 4'h0);
  endtask

  task automatic spiByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b0, {3'b000, b[i]});
  endtask

  task automatic qpiByte(input logic [7:0] b);
    applyStimulus(1'b0, b[7:4]);
    applyStimulus(1'b0, b[3:0]);
  endtask

  task automatic qpiAddr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) applyStimulus(1'b0, a[i*4 +: 4]);
  endtask

  task automatic write2(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    qpiByte(8'h38);
    qpiAddr(a);
    qpiByte(b0);
    qpiByte(b1);
    csHigh();
  endtask

  task automatic read2(input logic [23:0] a, output logic [7:0] b0, output logic [7:0] b1);
    qpiByte(8'hEB);
    qpiAddr(a);
    for (int i = 1; i <= WAIT; i++) begin
      applyStimulus(1'b0, 4'h0);
      if (i < WAIT) checkOutput("rd_wait_oe", 32'(oe), 32'd0);
    end
    checkOutput("rd_first_oe", 32'(oe), 32'd1);
    b0[7:4] = sioOut;
    applyStimulus(1'b0, 4'h0);
    b0[3:0] = sioOut;
    applyStimulus(1'b0, 4'h0);
    b1[7:4] = sioOut;
    applyStimulus(1'b0, 4'h0);
    b1[3:0] = sioOut;
    checkOutput("rd_burst_oe", 32'(oe), 32'd1);
    csHigh();
    checkOutput("rd_end_oe", 32'(oe), 32'd0);
  endtask

  initial begin
    resetN = 1'b0;
    cs     = 1'b1;
    sioIn  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_qpi", 32'(qpi), 32'd0);
    checkOutput("reset_oe", 32'(oe), 32'd0);
    checkOutput("reset_data", 32'(sioOut), 32'd0);
    checkOutput("reset_bad", 32'(bad), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Enter QPI over SPI.
    spiByte(8'h35);
    checkOutput("qpi_enter", 32'(qpi), 32'd1);
    csHigh();
    checkOutput("qpi_kept", 32'(qpi), 32'd1);
    checkOutput("enter_no_bad", 32'(badCount), 32'd0);

    // Write then read back immediately after cs-high.
    write2(24'h000123, 8'hA5, 8'h3C);
    read2(24'h000123, rb0, rb1);
    checkOutput("rd_123", 32'(rb0), 32'hA5);
    checkOutput("rd_124", 32'(rb1), 32'h3C);

    // Address wrap at the top of the 4 KiB array.
    write2(24'hFFFFFF, 8'h11, 8'h22);
    read2(24'h000FFF, rb0, rb1);
    checkOutput("wrap_fff", 32'(rb0), 32'h11);
    checkOutput("wrap_000", 32'(rb1), 32'h22);

    // Aborted write byte must not commit.
    write2(24'h000200, 8'h5A, 8'h6B);
    qpiByte(8'h38);
    qpiAddr(24'h000200);
    applyStimulus(1'b0, 4'hF);
    csHigh();
    checkOutput("abort_oe", 32'(oe), 32'd0);
    read2(24'h000200, rb0, rb1);
    checkOutput("abort_200", 32'(rb0), 32'h5A);
    checkOutput("abort_201", 32'(rb1), 32'h6B);

    // Unknown QPI command.
    qpiByte(8'h77);
    checkOutput("bad_qpi_pulse", 32'(bad), 32'd1);
    applyStimulus(1'b0, 4'h9);
    checkOutput("bad_qpi_clear", 32'(bad), 32'd0);
    checkOutput("bad_qpi_oe", 32'(oe), 32'd0);
    csHigh();
    checkOutput("bad_qpi_count", 32'(badCount), 32'd1);
    read2(24'h000123, rb0, rb1);
    checkOutput("bad_nowrite", 32'(rb0), 32'hA5);

    // Exit QPI, then an unknown SPI command.
    qpiByte(8'hF5);
    checkOutput("qpi_exit", 32'(qpi), 32'd0);
    csHigh();
    spiByte(8'h66);
    checkOutput("bad_spi_pulse", 32'(bad), 32'd1);
    checkOutput("bad_spi_qpi", 32'(qpi), 32'd0);
    csHigh();
    checkOutput("bad_spi_count", 32'(badCount), 32'd2);

    // Reset asserted in the middle of a read burst.
    spiByte(8'h35);
    csHigh();
    qpiByte(8'hEB);
    qpiAddr(24'h000123);
    repeat (WAIT + 1) applyStimulus(1'b0, 4'h0);
    checkOutput("midrd_oe", 32'(oe), 32'd1);
    @(negedge clk);
    resetN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrd_rst_oe", 32'(oe), 32'd0);
    checkOutput("midrd_rst_qpi", 32'(qpi), 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    cs     = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
